// File: rtl/check_node_pkg.sv
// rtl/check_node_pkg.sv - shared constants and encodings for the check-node insertion sorter
package check_node_pkg;

    localparam int WIDTH_DEFAULT     = 5;
    localparam int DEPTH_DEFAULT     = 4;
    localparam int CNT_WIDTH_DEFAULT = 3;

    localparam logic [WIDTH_DEFAULT:0] MAX_VALUE = '1;

    typedef enum logic {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } sorter_state_t;

    typedef enum logic [1:0] {
        CELL_HOLD      = 2'd0,
        CELL_INSERT    = 2'd1,
        CELL_SHIFT_OUT = 2'd2,
        CELL_CLEAR     = 2'd3
    } cell_mode_t;

endpackage

// File: rtl/check_node_sort_cell.sv
// rtl/check_node_sort_cell.sv - one sorted slot: hold, insert/shift-down, shift-out or clear
module check_node_sort_cell
    import check_node_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  cell_mode_t       mode,
    input  logic [WIDTH:0]   new_value,
    input  logic [WIDTH:0]   upper_value,
    input  logic [WIDTH:0]   lower_value,
    input  logic             upper_less,
    output logic [WIDTH:0]   slot_value,
    output logic             new_less
);

    localparam logic [WIDTH:0] SLOT_MAX = '1;

    // Strict compare keeps equal entries ahead of the newcomer.
    assign new_less = (new_value < slot_value);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_value <= SLOT_MAX;
        end else begin
            case (mode)
                CELL_INSERT: begin
                    if (upper_less) begin
                        slot_value <= upper_value;
                    end else if (new_less) begin
                        slot_value <= new_value;
                    end
                end
                CELL_SHIFT_OUT: slot_value <= lower_value;
                CELL_CLEAR:     slot_value <= SLOT_MAX;
                default:        slot_value <= slot_value;
            endcase
        end
    end

endmodule

// File: rtl/check_node_insertion_sorter.sv
// rtl/check_node_insertion_sorter.sv - keeps the DEPTH smallest values of a frame and drains them in order
module check_node_insertion_sorter
    import check_node_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEFAULT,
    parameter int DEPTH     = DEPTH_DEFAULT,
    parameter int CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH:0]   in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH:0]   out_data,
    output logic             out_last,
    input  logic             out_ready
);

    localparam logic [WIDTH:0]       SLOT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_DEPTH = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    sorter_state_t        state;
    sorter_state_t        state_next;
    cell_mode_t           cell_mode;
    logic [CNT_WIDTH-1:0] count;

    logic [WIDTH:0] slots       [DEPTH];
    logic [WIDTH:0] upper_vals  [DEPTH];
    logic [WIDTH:0] lower_vals  [DEPTH];
    logic           new_less    [DEPTH];
    logic           upper_less  [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_cell
        if (i == 0) begin : g_top
            assign upper_vals[i] = SLOT_MAX;
            assign upper_less[i] = 1'b0;
        end else begin : g_mid
            assign upper_vals[i] = slots[i-1];
            assign upper_less[i] = new_less[i-1];
        end

        // The bottom slot refills with MAX while draining.
        if (i == DEPTH - 1) begin : g_bottom
            assign lower_vals[i] = SLOT_MAX;
        end else begin : g_inner
            assign lower_vals[i] = slots[i+1];
        end

        check_node_sort_cell #(
            .WIDTH (WIDTH)
        ) u_cell (
            .clk         (clk),
            .rst_n       (rst_n),
            .mode        (cell_mode),
            .new_value   (in_data),
            .upper_value (upper_vals[i]),
            .lower_value (lower_vals[i]),
            .upper_less  (upper_less[i]),
            .slot_value  (slots[i]),
            .new_less    (new_less[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cell_mode  = CELL_HOLD;
        case (state)
            COLLECT: begin
                if (in_valid) begin
                    cell_mode = CELL_INSERT;
                    if (in_last) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (count == CNT_ONE) begin
                        cell_mode  = CELL_CLEAR;
                        state_next = COLLECT;
                    end else begin
                        cell_mode  = CELL_SHIFT_OUT;
                    end
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    // Count tracks valid entries, so a real MAX value still gets emitted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (state == COLLECT && in_valid) begin
            if (count < CNT_DEPTH) begin
                count <= count + CNT_ONE;
            end
        end else if (state == DRAIN && out_ready) begin
            count <= count - CNT_ONE;
        end
    end

    assign in_ready  = (state == COLLECT);
    assign out_valid = (state == DRAIN);
    assign out_data  = slots[0];
    assign out_last  = (state == DRAIN) && (count == CNT_ONE);

endmodule

// File: tb/tb_check_node_insertion_sorter.sv
// tb/tb_check_node_insertion_sorter.sv - self-checking bench for check_node_insertion_sorter
module tb_check_node_insertion_sorter;

    localparam int W     = 5;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [W:0]   in_data;
    logic         in_last;
    logic         in_ready;
    logic         out_valid;
    logic [W:0]   out_data;
    logic         out_last;
    logic         out_ready;

    int checks = 0;
    int errors = 0;
    int last_low = 0;
    logic [W:0] exp_q[$];

    check_node_insertion_sorter #(.WIDTH(W), .DEPTH(DEPTH), .CNT_WIDTH(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n;
        int beats [8];
        int ne;
        int exp [4];
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference: the frame's DEPTH smallest values in ascending order.
    task automatic build_expected(input logic [W:0] beats[$]);
        logic [W:0] pool[$];
        int keep;
        pool = beats;
        exp_q = {};
        keep = (beats.size() < DEPTH) ? beats.size() : DEPTH;
        for (int k = 0; k < keep; k++) begin
            int mi = 0;
            for (int j = 1; j < pool.size(); j++) begin
                if (pool[j] < pool[mi]) mi = j;
            end
            exp_q.push_back(pool[mi]);
            pool.delete(mi);
        end
    endtask

    task automatic send_frame(input logic [W:0] beats[$], input bit rand_gap);
        for (int i = 0; i < beats.size(); i++) begin
            int gaps = rand_gap ? int'($urandom_range(0, 2)) : 0;
            repeat (gaps) begin
                in_valid = 1'b0;
                in_data  = 6'($urandom);
                in_last  = 1'($urandom);
                @(posedge clk); #1;
                check("collect_idle_in_ready", int'(in_ready), 1);
            end
            in_valid = 1'b1;
            in_data  = beats[i];
            in_last  = (i == beats.size() - 1);
            check("collect_in_ready", int'(in_ready), 1);
            check("collect_out_valid", int'(out_valid), 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        check("drain_latency_valid", int'(out_valid), 1);
    endtask

    task automatic drain_frame(input logic [W:0] exp[$], input int stall_first, input bit rand_stall);
        int k = 0;
        int low = 0;
        int guard = 0;
        int stall = stall_first;
        while (k < exp.size() && guard < 200) begin
            guard++;
            low++;
            check("drain_valid", int'(out_valid), 1);
            check("drain_in_ready", int'(in_ready), 0);
            check("drain_data", int'(out_data), int'(exp[k]));
            check("drain_last", int'(out_last), (k == exp.size() - 1) ? 1 : 0);
            if (stall > 0) begin
                out_ready = 1'b0;
                in_valid  = 1'b1;
                in_data   = '0;
                in_last   = 1'b1;
                stall--;
            end else if (rand_stall && $urandom_range(0, 3) == 0) begin
                out_ready = 1'b0;
                in_valid  = 1'($urandom);
                in_data   = 6'($urandom);
                in_last   = 1'($urandom);
            end else begin
                out_ready = 1'b1;
                in_valid  = 1'b0;
                k++;
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        if (guard >= 200) check("drain_budget", guard, 0);
        check("done_in_ready", int'(in_ready), 1);
        check("done_out_valid", int'(out_valid), 0);
        last_low = low;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W:0] bq[$];
        logic [W:0] eq[$];

        vecs[0] = '{n: 6, beats: '{20, 7, 33, 7, 50, 3, 0, 0}, ne: 4, exp: '{3, 7, 7, 20}};
        vecs[1] = '{n: 2, beats: '{40, 10, 0, 0, 0, 0, 0, 0}, ne: 2, exp: '{10, 40, 0, 0}};
        vecs[2] = '{n: 1, beats: '{63, 0, 0, 0, 0, 0, 0, 0},  ne: 1, exp: '{63, 0, 0, 0}};
        vecs[3] = '{n: 2, beats: '{6, 1, 0, 0, 0, 0, 0, 0},   ne: 2, exp: '{1, 6, 0, 0}};
        vecs[4] = '{n: 3, beats: '{30, 25, 27, 0, 0, 0, 0, 0}, ne: 3, exp: '{25, 27, 30, 0}};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_last", int'(out_last), 0);
        check("reset_out_data", int'(out_data), 63);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed frames back to back; entries 3 and 4 start with no idle cycle.
        for (int v = 0; v < 5; v++) begin
            bq = {};
            eq = {};
            for (int i = 0; i < vecs[v].n; i++)  bq.push_back(6'(vecs[v].beats[i]));
            for (int i = 0; i < vecs[v].ne; i++) eq.push_back(6'(vecs[v].exp[i]));
            send_frame(bq, 1'b0);
            drain_frame(eq, 0, 1'b0);
            check("in_ready_low_cycles", last_low, vecs[v].ne);
        end

        // Backpressure at drain start, with ignored input pulses.
        bq = '{6'd9, 6'd5};
        eq = '{6'd5, 6'd9};
        send_frame(bq, 1'b0);
        drain_frame(eq, 3, 1'b0);
        check("stall_low_cycles", last_low, 5);

        // Reset in the middle of a drain.
        bq = '{6'd4, 6'd2, 6'd8};
        send_frame(bq, 1'b0);
        check("mid_first_data", int'(out_data), 2);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("mid_second_data", int'(out_data), 4);
        check("mid_second_valid", int'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_out_valid", int'(out_valid), 0);
        check("async_reset_in_ready", int'(in_ready), 1);
        check("async_reset_out_data", int'(out_data), 63);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        bq = '{6'd11};
        eq = '{6'd11};
        send_frame(bq, 1'b0);
        drain_frame(eq, 0, 1'b0);

        // Random frames against the reference model.
        for (int f = 0; f < 40; f++) begin
            int len = $urandom_range(1, 7);
            bq = {};
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 7) == 0) bq.push_back(6'd63);
                else bq.push_back(6'($urandom_range(0, 63)));
            end
            build_expected(bq);
            send_frame(bq, 1'b1);
            drain_frame(exp_q, 0, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/check_node_insertion_sorter.md
Name: check_node_insertion_sorter

Overview:
- Streaming insertion sorter for the NB-LDPC check node. Keeps the Depth smallest reliability values of a check-node frame in ascending order.
- Each register slot is loaded from one of three sources: its own value, the new value, or the value of the slot above it. This is the "previous vs. input" pick the check-node selector stage performs.
- After the frame ends, the sorted list is drained serially downstream with a valid/ready handshake.

Parameters:
- Width, 5, data MSB index; all values are Width+1 bits unsigned (0..63 at default)
- Depth, 4, number of sorted slots kept per frame
- Cnt_Width, 3, width of the inserted/drained counter; must satisfy 2^Cnt_Width > Depth

Ports:
- Clk  input  1  system clock, rising edge
- Rst_n  input  1  asynchronous active-low reset
- In_Valid  input  1  input beat valid
- In_Data  input  Width+1  unsigned reliability value
- In_Last  input  1  marks final beat of frame
- In_Ready  output  1  sorter accepts input this cycle
- Out_Valid  output  1  Out_Data holds a sorted entry
- Out_Data  output  Width+1  current smallest remaining entry
- Out_Last  output  1  marks final drained entry of frame
- Out_Ready  input  1  downstream accepts output this cycle

Behaviour:
- One clock, Clk. Reset Rst_n is asynchronous and active-low.
- Reset values:
  - all slots = MAX (all ones), count = 0, state = COLLECT
  - In_Ready = 1, Out_Valid = 0, Out_Last = 0, Out_Data = MAX
- States: COLLECT, DRAIN.
- COLLECT:
  - In_Ready = 1, Out_Valid = 0.
  - A beat is accepted when In_Valid = 1. Its value v is inserted in the same clock edge.
  - Slot i (0 = smallest) next value:
    - if v < slot[i-1] (i > 0): shift, take slot[i-1]
    - else if v < slot[i]: take v
    - else: hold
    - For i = 0 the shift case never applies.
  - The compare is strict, so a new value is placed after equal existing entries (stable). The value falling off slot Depth-1 is discarded.
  - count increments per accepted beat and saturates at Depth.
  - Accepted beat with In_Last = 1 moves to DRAIN next cycle. That beat is inserted too.
  - In_Valid = 0 means no change.
- DRAIN:
  - In_Ready = 0; In_Valid/In_Data are ignored.
  - Out_Valid = 1, Out_Data = slot[0].
  - Out_Last = 1 when count == 1.
  - On Out_Ready = 1:
    - slots shift toward slot 0 and slot Depth-1 fills with MAX
    - count decrements
    - if count was 1, return to COLLECT with all slots = MAX and count = 0
  - Out_Ready = 0 holds all outputs and state stable.
  - Exactly min(beats, Depth) entries are emitted per frame. An input value equal to MAX is still emitted, because the count decides emission, not the slot contents.
- Latency:
  - In_Last beat accepted at cycle t gives Out_Valid = 1 at t+1.
  - Last output handshake at cycle t gives In_Ready = 1 at t+1.
- Every frame has at least one beat, so count ≥ 1 on entry to DRAIN.
- Reset asserted mid-frame or mid-drain forces reset values immediately. The partial frame is discarded; no partial output follows.
- Outputs are registered or decoded from registered state only. There is no combinational path from In_* to Out_*.

Decomposition:
- Shared package check_node_pkg holds:
  - Width default, MAX constant (all ones, Width+1 bits)
  - state encoding COLLECT/DRAIN
  - Depth default
- One natural sub-module, check_node_sort_cell, per slot:
  - inputs: own value, upper-neighbour value, new value, lower-neighbour value, mode (insert/shift-out/clear/hold)
  - output: registered slot value
  - generates its "upper-is-less" compare for the next cell
- Top level instantiates Depth cells plus the FSM and counter.

Test Plan:
- Frame 20,7,33,7,50,3 (last on 3) -> outputs 3,7,7,20; Out_Last only on 20; 33 and 50 discarded; In_Ready = 0 for exactly 4 cycles.
- Short frame 40,10 (last on 10) -> exactly two outputs, 10 then 40; Out_Last on 40; In_Ready = 1 the cycle after 40 handshakes.
- Backpressure: frame 9,5 with Out_Ready = 0 for 3 cycles at drain start -> Out_Data = 5, Out_Valid = 1 held 3 cycles; In_Valid = 1 pulses with data 0 meanwhile are ignored; then 5,9 emitted.
- Single beat 63 (last) -> one output 63 with Out_Last = 1; no further Out_Valid.
- Reset mid-drain: frame 4,2,8 last, Rst_n low after the first output -> Out_Valid = 0 asynchronously. Next frame 11 (last) -> single output 11, with no residue from the old frame.
- Back-to-back frames: 6,1 (last) then immediately 30,25,27 (last) -> 1,6 then 25,27,30; the second frame's first beat is accepted the cycle after Out_Last handshake.
